// File: rtl/line_mem_responder_if.sv
// ---------------------------------------------------------------------------
// line_mem_responder_if
// Cache <-> memory line handshake bundle.
//   mem_read   : line read request (level, held until mem_ready)
//   mem_write  : line write request (level, held until mem_ready)
//   mem_addr   : line address, stable while a request is high
//   mem_wdata  : write line, stable while mem_write is high
//   mem_rdata  : read line, non-zero only while mem_ready is high
//   mem_ready  : one-cycle completion pulse from the responder
// Modports: master = cache/initiator side, slave = memory/responder side.
// ---------------------------------------------------------------------------
interface line_mem_responder_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) ();
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Line-granular memory slave serving 128-bit line reads/writes after a fixed
// programmable latency. Backing store behind the I/D caches.
// Ports:
//   clk        : clock, all state on posedge
//   proc_reset : synchronous active-high reset (storage is not cleared)
//   bus        : line_mem_responder_if.slave handshake
//   rd_cnt     : completed reads, saturating at 16'hFFFF
//   wr_cnt     : completed writes, saturating at 16'hFFFF
// Sequence: IDLE -> BUSY -> RESP -> GAP -> IDLE. mem_ready pulses in RESP,
// LATENCY cycles after acceptance; GAP guarantees a held request is not
// served twice.
// ---------------------------------------------------------------------------
module line_mem_responder #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 8
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  line_mem_responder_if.slave    bus,
  output logic [15:0]            rd_cnt,
  output logic [15:0]            wr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);
  localparam bit         LAT_ONE = (LATENCY == 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_op_q, wr_op_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0]       rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic [15:0]             rd_cnt_q, rd_cnt_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic                    req_s;

  logic [LINE_W-1:0]       line_mem [0:(1<<DEPTH_LOG2)-1];

  assign req_s = bus.mem_read | bus.mem_write;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= {DEPTH_LOG2{1'b0}};
      wr_op_q  <= 1'b0;
      wdata_q  <= {LINE_W{1'b0}};
      rdata_q  <= {LINE_W{1'b0}};
      ready_q  <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_op_q  <= wr_op_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Line storage: write commits at the end of RESP; a reset in that cycle aborts it.
  always_ff @(posedge clk) begin
    if (!proc_reset && (state_q == S_RESP) && wr_op_q) begin
      line_mem[idx_q] <= wdata_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          if (LAT_ONE) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_op_d  = wr_op_q;
    wdata_d  = wdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rdata_d  = {LINE_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          // Upper address bits are dropped on purpose: lines alias by low bits.
          idx_d   = bus.mem_addr[DEPTH_LOG2-1:0];
          // Write wins when both requests are high; the read is dropped.
          wr_op_d = bus.mem_write;
          wdata_d = bus.mem_wdata;
          cnt_d   = LAT_M1;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 8'd1;
      end
      S_RESP: begin
        if (wr_op_q) begin
          if (wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
          end else begin
            wr_cnt_d = wr_cnt_q;
          end
        end else begin
          if (rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
          end else begin
            rd_cnt_d = rd_cnt_q;
          end
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    ready_d = (state_d == S_RESP);
    // Storage is sampled into a register on the way into RESP, so mem_addr
    // never reaches mem_rdata combinationally.
    if ((state_d == S_RESP) && !wr_op_d) begin
      rdata_d = line_mem[idx_d];
    end else begin
      rdata_d = {LINE_W{1'b0}};
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = ready_q ? rdata_q : {LINE_W{1'b0}};
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_line_mem_responder
// Scoreboard bench: requests push {expected pulse cycle, expected rdata};
// per-DUT monitors pop and compare on every mem_ready. dut0 uses LATENCY=8,
// dut1 uses LATENCY=1.
// ---------------------------------------------------------------------------
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] rd0, wr0, rd1, wr1;
  int erd0 = 0, ewr0 = 0, erd1 = 0, ewr1 = 0;

  typedef struct {
    int           cyc;
    logic [127:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  line_mem_responder_if #(.ADDR_W(28), .LINE_W(128)) bus0 ();
  line_mem_responder_if #(.ADDR_W(28), .LINE_W(128)) bus1 ();

  line_mem_responder #(.ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(8), .LATENCY(8)) dut0 (
    .clk(clk), .proc_reset(rst0), .bus(bus0), .rd_cnt(rd0), .wr_cnt(wr0)
  );

  line_mem_responder #(.ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .proc_reset(rst1), .bus(bus1), .rd_cnt(rd1), .wr_cnt(wr1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dut0 monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus0.mem_ready === 1'b1) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut0_unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e0 = q0.pop_front();
          check("dut0_ready_cycle", 128'(cyc), 128'(e0.cyc));
          check("dut0_rdata", bus0.mem_rdata, e0.rdata);
        end
      end else begin
        check("dut0_rdata_idle", bus0.mem_rdata, 128'd0);
      end
    end
  end

  // dut1 monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus1.mem_ready === 1'b1) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut1_unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e1 = q1.pop_front();
          check("dut1_ready_cycle", 128'(cyc), 128'(e1.cyc));
          check("dut1_rdata", bus1.mem_rdata, e1.rdata);
        end
      end else begin
        check("dut1_rdata_idle", bus1.mem_rdata, 128'd0);
      end
    end
  end

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] d);
    if (sel == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_addr = a; bus0.mem_wdata = d;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_addr = a; bus1.mem_wdata = d;
    end
  endtask

  // Issue one request at the current negedge (DUT idle), wait for its pulse,
  // optionally hold the request through the turnaround cycle, then drop it.
  task automatic req(input int sel, input logic rd, input logic wr,
                     input logic [27:0] a, input logic [127:0] d,
                     input logic [127:0] exp_rd, input bit hold);
    exp_t e;
    int   lat;
    bit   seen;
    lat = (sel == 0) ? 8 : 1;
    drive(sel, rd, wr, a, d);
    e.cyc   = cyc + lat;
    e.rdata = exp_rd;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? bus0.mem_ready : bus1.mem_ready;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ready_timeout actual=no_pulse required=pulse (dut%0d addr %h)", sel, a);
    end
    @(negedge clk);
    if (!hold) drive(sel, 1'b0, 1'b0, 28'd0, 128'd0);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 28'd0, 128'd0);
  endtask

  task automatic check_cnts0(input string tag);
    check({tag, "_rd_cnt0"}, 128'(rd0), 128'(erd0));
    check({tag, "_wr_cnt0"}, 128'(wr0), 128'(ewr0));
  endtask

  task automatic check_cnts1(input string tag);
    check({tag, "_rd_cnt1"}, 128'(rd1), 128'(erd1));
    check({tag, "_wr_cnt1"}, 128'(wr1), 128'(ewr1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5s;
    int c0;
    a5s  = {16{8'hA5}};
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 28'd0, 128'd0);
    drive(1, 1'b0, 1'b0, 28'd0, 128'd0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("rst_ready0", 128'(bus0.mem_ready), 128'd0);
    check("rst_ready1", 128'(bus1.mem_ready), 128'd0);
    check_cnts0("rst");
    check_cnts1("rst");

    // 1: write 0x5 <- A5..A5
    req(0, 1'b0, 1'b1, 28'h0000005, a5s, 128'd0, 1'b0);
    ewr0++;
    check_cnts0("t1");

    // 2: read 0x5
    req(0, 1'b1, 1'b0, 28'h0000005, 128'd0, a5s, 1'b0);
    erd0++;
    check_cnts0("t2");

    // 3: cache-style held reads back to back (accept spacing LATENCY+2)
    req(0, 1'b0, 1'b1, 28'h0000010, 128'h1010_0000_0000_0000_0000_0000_0000_0010, 128'd0, 1'b0);
    req(0, 1'b0, 1'b1, 28'h0000011, 128'h1111_0000_0000_0000_0000_0000_0000_0011, 128'd0, 1'b0);
    ewr0 += 2;
    req(0, 1'b1, 1'b0, 28'h0000010, 128'd0, 128'h1010_0000_0000_0000_0000_0000_0000_0010, 1'b1);
    req(0, 1'b1, 1'b0, 28'h0000011, 128'd0, 128'h1111_0000_0000_0000_0000_0000_0000_0011, 1'b1);
    erd0 += 2;
    check_cnts0("t3");

    // 4: read+write together -> write wins; alias read of 0x103
    req(0, 1'b1, 1'b1, 28'h0000003, 128'h1, 128'd0, 1'b0);
    ewr0++;
    check_cnts0("t4a");
    req(0, 1'b1, 1'b0, 28'h0000103, 128'd0, 128'h1, 1'b0);
    erd0++;
    check_cnts0("t4b");

    // 5: reset mid-write aborts the commit and the pulse
    req(0, 1'b0, 1'b1, 28'h0000007, 128'h0777_0000_0000_0000_0000_0000_0000_7770, 128'd0, 1'b0);
    ewr0++;
    drive(0, 1'b0, 1'b1, 28'h0000007, 128'hBEEF);
    c0 = cyc;
    while (cyc < c0 + 4) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    drive(0, 1'b0, 1'b0, 28'd0, 128'd0);
    repeat (12) @(negedge clk);
    erd0 = 0;
    ewr0 = 0;
    check_cnts0("t5");
    req(0, 1'b1, 1'b0, 28'h0000007, 128'd0, 128'h0777_0000_0000_0000_0000_0000_0000_7770, 1'b0);
    erd0++;
    check_cnts0("t5b");

    // 6: LATENCY=1 build, then saturation of rd_cnt
    req(1, 1'b0, 1'b1, 28'h0000002, 128'hC0DE_CAFE, 128'd0, 1'b0);
    ewr1++;
    req(1, 1'b1, 1'b0, 28'h0000002, 128'd0, 128'hC0DE_CAFE, 1'b0);
    erd1++;
    check_cnts1("t6a");
    force dut1.rd_cnt_q = 16'hFFFF;
    #1;
    release dut1.rd_cnt_q;
    erd1 = 16'hFFFF;
    req(1, 1'b1, 1'b0, 28'h0000002, 128'd0, 128'hC0DE_CAFE, 1'b0);
    check_cnts1("t6b");

    repeat (4) @(negedge clk);
    check("q0_drained", 128'(q0.size()), 128'd0);
    check("q1_drained", 128'(q1.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
